// File: rtl/logic_pkg.sv
// Shared encodings for the logic unit: bitwise op codes and the accumulate FSM states.
package logic_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/logic_op.sv
// Purely combinational per-bit operation; every bit is independent, so there are no carries.
module logic_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic unit with an OR-accumulator and a single-entry valid/ready output register.
// Handshake: a beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
module logic_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_accum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output state_t           dbg_state
);

    logic [WIDTH-1:0] beat_r;
    logic [WIDTH-1:0] merged;
    logic             accept;
    logic             emit;
    logic             fold;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;

    logic_op #(.WIDTH(WIDTH)) u_op (
        .a  (in_a),
        .b  (in_b),
        .op (op_t'(in_op)),
        .y  (beat_r)
    );

    // Accumulate beats obey the same stall rule as emitting beats.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (in_last || !in_accum);
    assign fold     = accept && in_accum && !in_last;
    assign merged   = acc_q | beat_r;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // acc is zero in IDLE, so acc | r also covers the plain single-beat case.
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = merged;
            out_zero_d  = (merged == '0);
            acc_d       = '0;
            state_d     = IDLE;
        end else if (fold) begin
            acc_d   = merged;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign dbg_state = state_q;

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  operand beat present.
REQ-005 SHALL have port: in_ready  out  1  unit can accept a beat this cycle.
REQ-006 SHALL have ports: in_a, in_b  in  WIDTH  operands.
REQ-007 SHALL have port: in_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR (bitwise).
REQ-008 SHALL have port: in_accum  in  1  fold this beat's result into the OR-accumulator.
REQ-009 SHALL have port: in_last  in  1  final beat of an accumulation group.
REQ-010 SHALL have port: out_valid  out  1  result held.
REQ-011 SHALL have port: out_ready  in  1  consumer takes result.
REQ-012 SHALL have port: out_data  out  WIDTH  result.
REQ-013 SHALL have port: out_zero  out  1  out_data == 0.

Function
REQ-014 SHALL accept a beat exactly when in_valid && in_ready; beat result r = in_op(in_a, in_b), computed per bit, all WIDTH bits, no carries.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single-entry output register; full throughput when the consumer is always ready).
REQ-016 SHALL have states IDLE (acc == 0) and ACCUM.
REQ-017 SHALL, for an accepted beat in IDLE with in_accum=0, load out_data=r and out_valid=1 on the next edge (latency 1); stay IDLE.
REQ-018 SHALL, for an accepted beat with in_accum=1 and in_last=0, set acc <= acc | r, produce no output, and go to/stay in ACCUM.
REQ-019 SHALL, for an accepted beat with in_last=1 (any state, any in_accum), or with in_accum=0 while in ACCUM, emit out_data = acc | r, set out_valid=1, clear acc to 0, and go to IDLE.
REQ-020 SHALL drive out_zero = (out_data == 0), registered alongside out_data.
REQ-021 SHALL hold out_data and out_zero stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid on the edge where out_valid && out_ready unless a new emitting beat is accepted on the same edge; in that case it SHALL keep out_valid=1 and load the new data.
REQ-023 SHALL change neither state nor outputs in cycles with no accepted beat (except the out_valid clear of REQ-022).
REQ-024 SHALL apply the in_ready rule of REQ-015 even to non-emitting accumulate beats, so stalls are uniform.

Reset
REQ-025 SHALL on reset set out_valid=0, out_data=0, out_zero=0, acc=0, state=IDLE, overriding any same-cycle beat.
REQ-026 SHALL discard any partial accumulation on reset mid-group; the first beat after reset starts a new group.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset.

Structure
REQ-028 SHALL place op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the IDLE/ACCUM state encoding in shared package logic_pkg.
REQ-029 SHALL implement the per-bit operation in one combinational sub-module logic_op (params WIDTH; ports a, b, op, y), instantiated once.
REQ-030 SHALL have the remaining sequential logic (FSM, acc, output register) in logic_unit.

Verification
REQ-031 SHALL test: WIDTH=32, single beats OR/AND/XOR/NOR of 0xF0F0_0000 with 0x0FF0_00FF, out_ready=1 -> next-cycle outputs 0xFFF0_00FF, 0x00F0_0000, 0xFF00_00FF, 0x000F_FF00; out_zero=0 throughout.
REQ-032 SHALL test: accumulate OR-op beats 0x1,0x2,0x4 (last on third) -> single output 0x0000_0007 one cycle after the third beat, none earlier; state back to IDLE.
REQ-033 SHALL test: AND beat 0xAAAA_AAAA & 0x5555_5555 -> out_data=0, out_zero=1.
REQ-034 SHALL test: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data held; out_ready=1 with a beat pending -> back-to-back transfer, no lost or duplicated result.
REQ-035 SHALL test: reset asserted after two accumulate beats (0x10, 0x20) -> outputs 0; then a single in_last OR beat 0x1|0x0 -> out_data=0x0000_0001 (no stale 0x30).
REQ-036 SHALL test: WIDTH=8 instance, XOR 0xFF^0x0F -> 0xF0; NOR 0x00,0x00 -> 0xFF.
